// File: rtl/keypad_pkg.sv
// Shared types, coin codes and the key-code-to-coin mapping for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } scan_state_t;

  localparam logic [2:0] COIN_NONE    = 3'b111;
  localparam logic [2:0] COIN_DOLLAR  = 3'b101;
  localparam logic [2:0] COIN_QUARTER = 3'b110;
  localparam logic [2:0] COIN_DIME    = 3'b011;

  function automatic logic [2:0] coin_of(input int unsigned code);
    case (code)
      0:       coin_of = COIN_DOLLAR;
      1:       coin_of = COIN_QUARTER;
      2:       coin_of = COIN_DIME;
      default: coin_of = COIN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous row lines; 2-cycle latency, no backpressure.
// Resets to all-ones so an idle (unpressed) keypad is seen during and after reset.
module keypad_row_sync #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] meta;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta <= '1;
      o_q  <= '1;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Column-scanning keypad reader: debounced press -> one-cycle key strobe; optional coin code (KEYPAD_COIN_MAP_EN).
// Press-to-strobe within (N_COLS+DEBOUNCE_SCANS)*SCAN_DIV+3 clocks; no backpressure, strobes are fire-and-forget.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [N_ROWS-1:0]                 i_pad_row,
  output logic [N_COLS-1:0]                 o_pad_col,
  output logic                              o_key_valid,
  output logic [$clog2(N_ROWS*N_COLS)-1:0]  o_key_code,
  output logic                              o_key_held
`ifdef KEYPAD_COIN_MAP_EN
  ,
  output logic [2:0]                        o_coin
`endif
);

  localparam int CW  = $clog2(N_ROWS*N_COLS);
  localparam int CLW = $clog2(N_COLS);
  localparam int RW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int MW  = $clog2(DEBOUNCE_SCANS + 1);

  logic [N_ROWS-1:0] row_s;
  logic [DW-1:0]     cnt;
  logic [CLW-1:0]    col, col_d, col_next;
  logic [MW-1:0]     match, match_d;
  logic [CW-1:0]     cand, cand_d, code_now;
  logic [RW-1:0]     cand_row, cand_row_d, win_row;
  scan_state_t       state, state_d;
  logic              sample, any_low, accept, release_done;

  keypad_row_sync #(.W(N_ROWS)) u_row_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_pad_row),
    .o_q   (row_s)
  );

  assign sample   = (cnt == DW'(SCAN_DIV - 1));
  assign any_low  = ~&row_s;
  assign col_next = (col == CLW'(N_COLS - 1)) ? '0 : col + 1'b1;
  assign code_now = CW'(win_row) * CW'(N_COLS) + CW'(col);

  // Descending loop so the lowest low row index is the last (winning) assignment.
  always_comb begin
    win_row = '0;
    for (int i = N_ROWS - 1; i >= 0; i--) begin
      if (!row_s[i]) win_row = RW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < N_COLS; i++) o_pad_col[i] = (CLW'(i) != col);
  end

  always_comb begin
    state_d      = state;
    col_d        = col;
    match_d      = match;
    cand_d       = cand;
    cand_row_d   = cand_row;
    accept       = 1'b0;
    release_done = 1'b0;
    if (sample) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            cand_d     = code_now;
            cand_row_d = win_row;
            match_d    = MW'(1);
            state_d    = DEBOUNCE;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              match_d = '0;
              state_d = HELD;
            end
          end else begin
            col_d = col_next;
          end
        end
        DEBOUNCE: begin
          if (any_low && (win_row == cand_row)) begin
            if (match == MW'(DEBOUNCE_SCANS - 1)) begin
              accept  = 1'b1;
              match_d = '0;
              state_d = HELD;
            end else begin
              match_d = match + 1'b1;
            end
          end else begin
            match_d = '0;
            col_d   = col_next;
            state_d = SCAN;
          end
        end
        HELD: begin
          // match counts consecutive all-high samples here.
          if (any_low) begin
            match_d = '0;
          end else if (match == MW'(DEBOUNCE_SCANS - 1)) begin
            release_done = 1'b1;
            match_d      = '0;
            col_d        = col_next;
            state_d      = SCAN;
          end else begin
            match_d = match + 1'b1;
          end
        end
        default: begin
          match_d = '0;
          state_d = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= SCAN;
      col         <= '0;
      cnt         <= '0;
      match       <= '0;
      cand        <= '0;
      cand_row    <= '0;
      o_key_valid <= 1'b0;
      o_key_code  <= '0;
      o_key_held  <= 1'b0;
    end else begin
      state       <= state_d;
      col         <= col_d;
      cnt         <= sample ? '0 : cnt + 1'b1;
      match       <= match_d;
      cand        <= cand_d;
      cand_row    <= cand_row_d;
      o_key_valid <= accept;
      if (accept) begin
        o_key_code <= cand_d;
        o_key_held <= 1'b1;
      end else if (release_done) begin
        o_key_held <= 1'b0;
      end
    end
  end

`ifdef KEYPAD_COIN_MAP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) o_coin <= COIN_NONE;
    else       o_coin <= accept ? coin_of(32'(cand_d)) : COIN_NONE;
  end
`endif

endmodule
